// File: rtl/radix4_mult_pkg.sv
// Shared types and constants for the radix-4 sequential multiplier core.
// Holds the controller state encoding and the 2-bit multiplier digit values.
package radix4_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] D0 = 2'd0;
    localparam logic [1:0] D1 = 2'd1;
    localparam logic [1:0] D2 = 2'd2;
    localparam logic [1:0] D3 = 2'd3;

endpackage : radix4_mult_pkg

// File: rtl/radix4_pp_select.sv
// Radix-4 partial-product selector: maps one multiplier digit to 0, A, 2A or 3A.
// Purely combinational; 3A comes precomputed so no adder sits on this path.
module radix4_pp_select
    import radix4_mult_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE+1:0] a3,
    input  logic [1:0]      d,
    output logic [SIZE+1:0] pp
);

    // NOTE: assigning a default before the case keeps this block latch-free even
    // if a digit value were ever left out of the case items.
    always_comb begin
        pp = '0;
        case (d)
            D0:      pp = '0;
            D1:      pp = {2'b00, a};
            D2:      pp = {1'b0, a, 1'b0};
            D3:      pp = a3;
            default: pp = '0;
        endcase
    end

endmodule : radix4_pp_select

// File: rtl/radix4_mult_core.sv
// Sequential unsigned radix-4 multiplier: one 2-bit multiplier digit per cycle,
// with a start/done handshake and a fixed latency of SIZE/2 + 2 cycles.
module radix4_mult_core
    import radix4_mult_pkg::*;
#(
    parameter int SIZE = 8  // must be even and >= 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE-1:0]   a_in,
    input  logic [SIZE-1:0]   b_in,
    output logic              busy,
    output logic              done,
    output logic [2*SIZE-1:0] product
);

    localparam int N  = SIZE / 2;
    localparam int CW = $clog2(N) + 1;
    localparam int PW = 2 * SIZE;
    localparam int XW = SIZE + 2;

    state_t          state_q, state_d;
    logic [SIZE-1:0] a_q, a_d;
    logic [SIZE-1:0] b_q, b_d;
    logic [XW-1:0]   a3_q, a3_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   product_q, product_d;
    logic [XW-1:0]   pp;
    logic            accept;
    logic            last_digit;

    // Start is only honoured when no operation is in flight.
    assign accept     = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_digit = (cnt_q == CW'(N - 1));

    radix4_pp_select #(
        .SIZE (SIZE)
    ) u_pp_select (
        .a  (a_q),
        .a3 (a3_q),
        .d  (b_q[1:0]),
        .pp (pp)
    );

    // NOTE: every datapath register is cleared by reset as well, so an aborted
    // operation can never leak a partial product into the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking assignments make all flops update together from
            // pre-edge values, independent of statement order.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = PRE;
            PRE:     state_d = CALC;
            CALC:    if (last_digit) state_d = DONE;
            DONE:    state_d = accept ? PRE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            PRE, CALC: busy = 1'b1;
            DONE:      done = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q       <= '0;
            b_q       <= '0;
            a3_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            a3_q      <= a3_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        a3_d      = a3_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    a_d       = a_in;
                    b_d       = b_in;
                    cnt_d     = '0;
                    product_d = '0;
                end
            end
            PRE: begin
                // 3A is formed once here so the digit loop needs only one adder.
                a3_d = XW'(a_q) + (XW'(a_q) << 1);
            end
            CALC: begin
                product_d = product_q + (PW'(pp) << {cnt_q, 1'b0});
                b_d       = b_q >> 2;
                cnt_d     = cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    assign product = product_q;

endmodule : radix4_mult_core

// File: tb/tb_radix4_mult_core.sv
// Self-checking bench for radix4_mult_core: directed scenarios at SIZE=8 and
// randomized sweeps at SIZE=2 and SIZE=16 against an arithmetic reference.
module tb_radix4_mult_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        s8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        s2, busy2, done2;
    logic [1:0]  a2, b2;
    logic [3:0]  p2;

    logic        s16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    int total = 0;
    int bad   = 0;

    radix4_mult_core #(.SIZE(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .a_in(a8), .b_in(b8),
        .busy(busy8), .done(done8), .product(p8)
    );

    radix4_mult_core #(.SIZE(2)) dut2 (
        .clk(clk), .rst(rst), .start(s2), .a_in(a2), .b_in(b2),
        .busy(busy2), .done(done2), .product(p2)
    );

    radix4_mult_core #(.SIZE(16)) dut16 (
        .clk(clk), .rst(rst), .start(s16), .a_in(a16), .b_in(b16),
        .busy(busy16), .done(done16), .product(p16)
    );

    // Runs one SIZE=8 operation starting at the current negedge. Expected timing:
    // busy in cycles 1..5, done in cycle 6, product == a*b then, product 0 in cycle 1.
    // An optional start pulse with other operands is injected in cycle pulse_cyc.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input int pulse_cyc,
                       input logic [7:0] pa, input logic [7:0] pb, input string name);
        logic [15:0] exp_p;
        logic        exp_busy, exp_done;
        bit          seen;
        exp_p = 16'(a) * 16'(b);
        s8 = 1'b1; a8 = a; b8 = b;
        @(negedge clk);
        seen = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            exp_busy = (c <= 5);
            exp_done = (c == 6);
            total++;
            if (busy8 !== exp_busy) begin
                bad++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, c, busy8, exp_busy);
            end
            total++;
            if (done8 !== exp_done) begin
                bad++;
                $display("FAIL %s done cycle %0d: got %b want %b", name, c, done8, exp_done);
            end
            if (c == 1) begin
                total++;
                if (p8 !== 16'd0) begin
                    bad++;
                    $display("FAIL %s product cleared: got %0d want 0", name, p8);
                end
            end
            if (done8 === 1'b1) begin
                seen = 1;
                total++;
                if (p8 !== exp_p) begin
                    bad++;
                    $display("FAIL %s product: got %0d want %0d", name, p8, exp_p);
                end
            end else begin
                if (c == pulse_cyc) begin
                    s8 = 1'b1; a8 = pa; b8 = pb;
                end else begin
                    s8 = 1'b0;
                end
                @(negedge clk);
            end
        end
        s8 = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no done within 20 cycles", name);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        s8 = 0; a8 = '0; b8 = '0;
        s2 = 0; a2 = '0; b2 = '0;
        s16 = 0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy8, done8, p8} !== 18'd0) begin
            bad++;
            $display("FAIL reset8: got busy=%b done=%b p=%0d want 0 0 0", busy8, done8, p8);
        end
        total++;
        if ({busy2, done2, p2} !== 6'd0) begin
            bad++;
            $display("FAIL reset2: got busy=%b done=%b p=%0d want 0 0 0", busy2, done2, p2);
        end
        total++;
        if ({busy16, done16, p16} !== 34'd0) begin
            bad++;
            $display("FAIL reset16: got busy=%b done=%b p=%0d want 0 0 0", busy16, done16, p16);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({busy8, done8} !== 2'b00) begin
            bad++;
            $display("FAIL idle8 after reset: got busy=%b done=%b want 0 0", busy8, done8);
        end
    endtask

    task automatic test_basic;
        op8(8'd13, 8'd11, -1, 8'd0, 8'd0, "basic_13x11");
        @(negedge clk);
        total++;
        if (p8 !== 16'd143 || done8 !== 1'b0) begin
            bad++;
            $display("FAIL hold_143: got p=%0d done=%b want 143 0", p8, done8);
        end
    endtask

    task automatic test_extremes;
        op8(8'd255, 8'd255, -1, 8'd0, 8'd0, "max_255x255");
        @(negedge clk);
        op8(8'd0, 8'd200, -1, 8'd0, 8'd0, "zero_0x200");
        @(negedge clk);
        op8(8'd200, 8'd0, -1, 8'd0, 8'd0, "zero_200x0");
        @(negedge clk);
    endtask

    task automatic test_ignored_start;
        op8(8'd7, 8'd9, 3, 8'd1, 8'd1, "ignored_calc");
        @(negedge clk);
        op8(8'd7, 8'd9, 1, 8'd1, 8'd1, "ignored_pre");
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        op8(8'd5, 8'd5, -1, 8'd0, 8'd0, "b2b_first_5x5");
        total++;
        if (done8 !== 1'b1 || p8 !== 16'd25) begin
            bad++;
            $display("FAIL b2b_done_cycle: got done=%b p=%0d want 1 25", done8, p8);
        end
        op8(8'd3, 8'd3, -1, 8'd0, 8'd0, "b2b_second_3x3");
        @(negedge clk);
        total++;
        if (p8 !== 16'd9 || done8 !== 1'b0 || busy8 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: got p=%0d done=%b busy=%b want 9 0 0", p8, done8, busy8);
        end
    endtask

    task automatic test_reset_mid_calc;
        s8 = 1'b1; a8 = 8'd255; b8 = 8'd255;
        @(negedge clk);
        s8 = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy8 !== 1'b1 || p8 === 16'd0) begin
            bad++;
            $display("FAIL pre_abort: got busy=%b p=%0d want busy 1 p nonzero", busy8, p8);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({busy8, done8, p8} !== 18'd0) begin
            bad++;
            $display("FAIL abort: got busy=%b done=%b p=%0d want 0 0 0", busy8, done8, p8);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        op8(8'd6, 8'd7, -1, 8'd0, 8'd0, "after_abort_6x7");
        @(negedge clk);
    endtask

    task automatic test_sweep2;
        logic [3:0] exp_p;
        int         lat;
        for (int i = 0; i < 1000; i++) begin
            a2 = 2'($urandom);
            b2 = 2'($urandom);
            exp_p = 4'(a2) * 4'(b2);
            s2 = 1'b1;
            @(negedge clk);
            s2 = 1'b0;
            lat = 0;
            for (int c = 1; c <= 10; c++) begin
                if (done2 === 1'b1) begin
                    lat = c;
                    break;
                end
                @(negedge clk);
            end
            total++;
            if (lat != 3) begin
                bad++;
                $display("FAIL sweep2 latency %0dx%0d: got %0d want 3", a2, b2, lat);
            end
            total++;
            if (p2 !== exp_p) begin
                bad++;
                $display("FAIL sweep2 product %0dx%0d: got %0d want %0d", a2, b2, p2, exp_p);
            end
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end
    endtask

    task automatic test_sweep16;
        logic [31:0] exp_p;
        int          lat;
        for (int i = 0; i < 1000; i++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            if (i == 0) begin a16 = 16'hFFFF; b16 = 16'hFFFF; end
            exp_p = 32'(a16) * 32'(b16);
            s16 = 1'b1;
            @(negedge clk);
            s16 = 1'b0;
            lat = 0;
            for (int c = 1; c <= 20; c++) begin
                if (done16 === 1'b1) begin
                    lat = c;
                    break;
                end
                @(negedge clk);
            end
            total++;
            if (lat != 10) begin
                bad++;
                $display("FAIL sweep16 latency %0dx%0d: got %0d want 10", a16, b16, lat);
            end
            total++;
            if (p16 !== exp_p) begin
                bad++;
                $display("FAIL sweep16 product %0dx%0d: got %0d want %0d", a16, b16, p16, exp_p);
            end
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_extremes;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid_calc;
        test_sweep2;
        test_sweep16;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_radix4_mult_core
